// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
package imem_arb_pkg;

    localparam int unsigned IMEM_ADDR_W = 13;
    localparam int unsigned IMEM_DATA_W = 32;

    typedef enum logic {ST_BOOT, ST_RUN} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LD} arb_owner_e;

endpackage

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous-read imem between IF fetch and a loader/debug port.
// Optional macro IMEM_ARB_ERR_EN adds if_err_o/ld_err_o and address checking.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = IMEM_ADDR_W,
    parameter int unsigned DATA_W   = IMEM_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [31:0]       ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    input  logic              ld_done_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
`ifdef IMEM_ARB_ERR_EN
    output logic              if_err_o,
    output logic              ld_err_o,
`endif
    output logic              boot_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    arb_state_e  state_q, state_d;
    arb_owner_e  rsp_owner_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [3:0]  wait_cnt_q;

    logic              if_gnt, ld_gnt;
    logic              if_bad, ld_bad;
    logic [ADDR_W-1:0] if_word, ld_word;

    assign if_word = if_addr_i[ADDR_W+1:2];
    assign ld_word = ld_addr_i[ADDR_W+1:2];

`ifdef IMEM_ARB_ERR_EN
    assign if_bad = (if_addr_i[1:0] != 2'b00) || (if_addr_i[31:ADDR_W+2] != '0);
    assign ld_bad = (ld_addr_i[1:0] != 2'b00) || (ld_addr_i[31:ADDR_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                                ld_addr_i[31:ADDR_W+2], ld_addr_i[1:0]};
    assign if_bad = 1'b0;
    assign ld_bad = 1'b0;
`endif

    // Grant and next-state logic; nothing is granted while reset is asserted.
    always_comb begin
        if_gnt  = 1'b0;
        ld_gnt  = 1'b0;
        state_d = state_q;
        if (!rst_i) begin
            unique case (state_q)
                ST_BOOT: begin
                    ld_gnt = ld_req_i;
                    if (ld_done_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (if_req_i && ld_req_i) begin
                        if (wait_cnt_q == MAX_WAIT_C) begin
                            ld_gnt = 1'b1;
                        end else begin
                            if_gnt = 1'b1;
                        end
                    end else begin
                        if_gnt = if_req_i;
                        ld_gnt = ld_req_i;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ld_gnt) begin
            mem_en_o    = !ld_bad;
            mem_we_o    = ld_we_i && !ld_bad;
            mem_addr_o  = ld_word;
            mem_wdata_o = ld_wdata_i;
        end else if (if_gnt) begin
            mem_en_o   = !if_bad;
            mem_addr_o = if_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_BOOT;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_RUN) && ld_req_i && !ld_gnt) begin
                if (wait_cnt_q != MAX_WAIT_C) begin
                    wait_cnt_q <= wait_cnt_q + 4'd1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
            // An errored write still records the owner so its err pulse lands on the loader.
            rsp_valid_q <= if_gnt || (ld_gnt && !ld_we_i);
            rsp_err_q   <= (if_gnt && if_bad) || (ld_gnt && ld_bad);
            if (if_gnt || ld_gnt) begin
                rsp_owner_q <= ld_gnt ? OWN_LD : OWN_IF;
            end
        end
    end

    logic rsp_live;
    assign rsp_live = rsp_valid_q && !rst_i;

    assign if_gnt_o    = if_gnt;
    assign ld_gnt_o    = ld_gnt;
    assign boot_done_o = (state_q == ST_RUN);

    assign if_rvalid_o = rsp_live && (rsp_owner_q == OWN_IF);
    assign ld_rvalid_o = rsp_live && (rsp_owner_q == OWN_LD);
    assign if_rdata_o  = (if_rvalid_o && !rsp_err_q) ? mem_rdata_i : '0;
    assign ld_rdata_o  = (ld_rvalid_o && !rsp_err_q) ? mem_rdata_i : '0;

`ifdef IMEM_ARB_ERR_EN
    assign if_err_o = rsp_err_q && !rst_i && (rsp_owner_q == OWN_IF);
    assign ld_err_o = rsp_err_q && !rst_i && (rsp_owner_q == OWN_LD);
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed scoreboard bench for imem_arbiter with a 1-cycle sync-RAM model on mem_*.
// Build with IMEM_ARB_ERR_EN defined to also exercise the error responses.
module imem_sram_model #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        rdata = '0;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

module tb_imem_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0]   if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          ld_req_i, ld_we_i, ld_done_i, ld_gnt_o, ld_rvalid_o;
    logic [31:0]   ld_addr_i;
    logic [DW-1:0] ld_wdata_i, ld_rdata_o;
    logic          boot_done_o, mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;
    logic          if_err_o, ld_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic        own_ld;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
        .ld_wdata_i(ld_wdata_i), .ld_done_i(ld_done_i), .ld_gnt_o(ld_gnt_o),
        .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
`ifdef IMEM_ARB_ERR_EN
        .if_err_o(if_err_o), .ld_err_o(ld_err_o),
`endif
        .boot_done_o(boot_done_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

`ifndef IMEM_ARB_ERR_EN
    assign if_err_o = 1'b0;
    assign ld_err_o = 1'b0;
`endif

    imem_sram_model #(.AW(AW), .DW(DW)) sram (
        .clk(clk), .en(mem_en_o), .we(mem_we_o), .addr(mem_addr_o),
        .wdata(mem_wdata_o), .rdata(mem_rdata_i)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue an expected response for the cycle after the current one.
    task automatic push(input logic own_ld, input logic rv, input logic err, input logic [31:0] data);
        rsp_t e;
        e.due = cyc + 1; e.own_ld = own_ld; e.rv = rv; e.err = err; e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk1 ("rsp_if_rvalid", if_rvalid_o, !e.own_ld && e.rv);
            chk1 ("rsp_ld_rvalid", ld_rvalid_o, e.own_ld && e.rv);
            chk32("rsp_if_rdata", if_rdata_o, (!e.own_ld && e.rv) ? e.data : 32'h0);
            chk32("rsp_ld_rdata", ld_rdata_o, (e.own_ld && e.rv) ? e.data : 32'h0);
            chk1 ("rsp_if_err", if_err_o, !e.own_ld && e.err);
            chk1 ("rsp_ld_err", ld_err_o, e.own_ld && e.err);
        end else begin
            chk1 ("idle_if_rvalid", if_rvalid_o, 1'b0);
            chk1 ("idle_ld_rvalid", ld_rvalid_o, 1'b0);
            chk1 ("idle_if_err", if_err_o, 1'b0);
            chk1 ("idle_ld_err", ld_err_o, 1'b0);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; if_addr_i = '0;
        ld_req_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_wdata_i = '0; ld_done_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        // Requests during reset are never granted.
        if_req_i = 1'b1; ld_req_i = 1'b1; ld_we_i = 1'b1;
        smp();
        chk1("rst_if_gnt", if_gnt_o, 1'b0);
        chk1("rst_ld_gnt", ld_gnt_o, 1'b0);
        chk1("rst_mem_en", mem_en_o, 1'b0);
        nxt();
        rst_i = 1'b0;
        idle_inputs();
        smp();
        chk1("post_rst_boot_done", boot_done_o, 1'b0);
        chk1("post_rst_if_gnt", if_gnt_o, 1'b0);
        chk1("post_rst_ld_gnt", ld_gnt_o, 1'b0);
        chk1("post_rst_mem_en", mem_en_o, 1'b0);

        // Boot load with fetch pressure.
        nxt();
        if_req_i = 1'b1; if_addr_i = 32'h4;
        ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h0; ld_wdata_i = 32'h0000_0013;
        smp();
        chk1 ("boot_if_gnt0", if_gnt_o, 1'b0);
        chk1 ("boot_ld_gnt0", ld_gnt_o, 1'b1);
        chk1 ("boot_mem_we0", mem_we_o, 1'b1);
        chk32("boot_mem_addr0", 32'(mem_addr_o), 32'd0);
        chk32("boot_mem_wdata0", mem_wdata_o, 32'h0000_0013);
        nxt();
        ld_addr_i = 32'h4; ld_wdata_i = 32'h0010_0093;
        smp();
        chk1 ("boot_if_gnt1", if_gnt_o, 1'b0);
        chk1 ("boot_ld_gnt1", ld_gnt_o, 1'b1);
        chk32("boot_mem_addr1", 32'(mem_addr_o), 32'd1);
        nxt();
        ld_req_i = 1'b0; ld_we_i = 1'b0; ld_done_i = 1'b1;
        smp();
        chk1("boot_done_pulse_if_gnt", if_gnt_o, 1'b0);
        chk1("boot_done_still_boot", boot_done_o, 1'b0);
        nxt();
        ld_done_i = 1'b0;
        smp();
        chk1 ("run_boot_done", boot_done_o, 1'b1);
        chk1 ("run_if_gnt", if_gnt_o, 1'b1);
        chk1 ("run_mem_en", mem_en_o, 1'b1);
        chk32("run_mem_addr", 32'(mem_addr_o), 32'd1);
        push(1'b0, 1'b1, 1'b0, 32'h0010_0093);

        // Starvation: loader read of 0x0 against continuous fetch of 0x4.
        nxt();
        ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk1("starve_ld_denied", ld_gnt_o, 1'b0);
            chk1("starve_if_gnt", if_gnt_o, 1'b1);
            push(1'b0, 1'b1, 1'b0, 32'h0010_0093);
            nxt();
        end
        smp();
        chk1 ("starve_ld_gnt", ld_gnt_o, 1'b1);
        chk1 ("starve_if_held", if_gnt_o, 1'b0);
        chk32("starve_mem_addr", 32'(mem_addr_o), 32'd0);
        push(1'b1, 1'b1, 1'b0, 32'h0000_0013);
        nxt();
        ld_req_i = 1'b0;
        // ld_done_i is ignored once running.
        ld_done_i = 1'b1;
        smp();
        chk32("starve_wait_cnt_clr", 32'(dut.wait_cnt_q), 32'd0);
        chk1 ("run_if_gnt_lone", if_gnt_o, 1'b1);
        push(1'b0, 1'b1, 1'b0, 32'h0010_0093);

        // Loader write of 0x8 produces no response.
        nxt();
        ld_done_i = 1'b0; if_req_i = 1'b0;
        ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h8; ld_wdata_i = 32'h0020_0113;
        smp();
        chk1 ("wr_ld_gnt", ld_gnt_o, 1'b1);
        chk1 ("wr_mem_we", mem_we_o, 1'b1);
        chk32("wr_mem_addr", 32'(mem_addr_o), 32'd2);
        chk1 ("wr_boot_done_kept", boot_done_o, 1'b1);

        // Back-to-back fetches.
        nxt();
        ld_req_i = 1'b0; ld_we_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0;
        smp(); chk1("pipe_gnt0", if_gnt_o, 1'b1); push(1'b0, 1'b1, 1'b0, 32'h0000_0013);
        nxt(); if_addr_i = 32'h4;
        smp(); chk1("pipe_gnt1", if_gnt_o, 1'b1); push(1'b0, 1'b1, 1'b0, 32'h0010_0093);
        nxt(); if_addr_i = 32'h8;
        smp(); chk1("pipe_gnt2", if_gnt_o, 1'b1); push(1'b0, 1'b1, 1'b0, 32'h0020_0113);

`ifdef IMEM_ARB_ERR_EN
        nxt(); if_addr_i = 32'h2;
        smp();
        chk1("err_mis_gnt", if_gnt_o, 1'b1);
        chk1("err_mis_mem_en", mem_en_o, 1'b0);
        push(1'b0, 1'b1, 1'b1, 32'h0);
        nxt(); if_addr_i = 32'h8000;
        smp();
        chk1("err_oor_gnt", if_gnt_o, 1'b1);
        chk1("err_oor_mem_en", mem_en_o, 1'b0);
        push(1'b0, 1'b1, 1'b1, 32'h0);
        nxt();
        if_req_i = 1'b0;
        ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h1; ld_wdata_i = 32'hdead_beef;
        smp();
        chk1("err_wr_gnt", ld_gnt_o, 1'b1);
        chk1("err_wr_mem_en", mem_en_o, 1'b0);
        push(1'b1, 1'b0, 1'b1, 32'h0);
        nxt();
        ld_req_i = 1'b0; ld_we_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h4;
`else
        // Base build: byte offset and upper address bits are ignored.
        nxt(); if_addr_i = 32'h0000_8006;
`endif
        smp();
        chk1 ("alias_gnt", if_gnt_o, 1'b1);
        chk32("alias_mem_addr", 32'(mem_addr_o), 32'd1);
        push(1'b0, 1'b1, 1'b0, 32'h0010_0093);

        // Reset in the cycle after a fetch grant discards the response.
        nxt(); if_addr_i = 32'h0;
        smp(); chk1("rstmid_gnt", if_gnt_o, 1'b1);
        nxt(); rst_i = 1'b1;
        smp(); chk1("rstmid_if_gnt_in_rst", if_gnt_o, 1'b0);
        nxt(); rst_i = 1'b0;
        smp();
        chk1("rstmid_boot_done", boot_done_o, 1'b0);
        chk1("rstmid_if_gnt_boot", if_gnt_o, 1'b0);
        nxt(); idle_inputs();
        smp();
        nxt();
        smp();
        chk32("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
